tx_scheduler: RTL and testbench

TX_SCHEDULER -- requirements
Module: tx_scheduler

---
 rtl/txrx_pkg.sv | 25 ++
 rtl/rr_arbiter.sv | 38 +++
 rtl/tx_scheduler.sv | 151 +++++++++++++++
 tb/tb_tx_scheduler.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/txrx_pkg.sv
// Shared widths, FSM state encoding and packet layout for the transmit scheduler.
package txrx_pkg;

  localparam int unsigned ID_W_DFLT   = 2;
  localparam int unsigned DATA_W_DFLT = 2;
  localparam int unsigned PKT_W_DFLT  = 2 * ID_W_DFLT + DATA_W_DFLT;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_e;

  // Packet at default widths; dest occupies the MSBs
  typedef struct packed {
    logic [ID_W_DFLT-1:0]   dest;
    logic [ID_W_DFLT-1:0]   src;
    logic [DATA_W_DFLT-1:0] data;
  } pkt_t;

  // Index width that stays legal for a single requester
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: lowest requester index at or above ptr, wrapping.
module rr_arbiter
  import txrx_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned IDX_W = idx_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic             any_c,
  output logic [N_REQ-1:0] sel_oh_c,
  output logic [IDX_W-1:0] sel_idx_c
);

  localparam int unsigned SUM_W = IDX_W + 1;

  logic [N_REQ-1:0] rot;
  logic [SUM_W-1:0] sum;

  // rot[k] is requester (ptr + k) mod N_REQ
  assign rot = N_REQ'({req, req} >> ptr);

  always_comb begin
    any_c = 1'b0;
    sum   = '0;
    // Walk downwards so the lowest rotated offset wins
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        any_c = 1'b1;
        sum   = {1'b0, ptr} + SUM_W'(k);
      end
    end
    if (sum >= SUM_W'(N_REQ)) sum = sum - SUM_W'(N_REQ);
    sel_idx_c = IDX_W'(sum);
    sel_oh_c  = any_c ? (N_REQ'(1) << sel_idx_c) : '0;
  end

endmodule

// File: rtl/tx_scheduler.sv
// Round-robin scheduler feeding N_REQ requesters into one valid/ready transmitter.
// Define TX_SCHEDULER_TIMEOUT_EN to drop packets whose ack wait exceeds TIMEOUT_CYC.
module tx_scheduler
  import txrx_pkg::*;
#(
  parameter int unsigned N_REQ       = 4,
  parameter int unsigned ID_W        = ID_W_DFLT,
  parameter int unsigned DATA_W      = DATA_W_DFLT,
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [ID_W-1:0]            node_id,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ*ID_W-1:0]      req_dest,
  input  logic [N_REQ*DATA_W-1:0]    req_data,
  output logic [N_REQ-1:0]           grant,
  output logic [2*ID_W+DATA_W-1:0]   tx_out,
  output logic                       tx_valid,
  input  logic                       tx_ready,
  output logic                       busy,
  output logic                       tx_err
);

  localparam int unsigned PKT_W = 2 * ID_W + DATA_W;
  localparam int unsigned IDX_W = idx_w(N_REQ);

  localparam logic [0:0] IDLE = ST_IDLE;
  localparam logic [0:0] SEND = ST_SEND;

  if (TIMEOUT_CYC < 2) begin : g_bad_timeout
    $error("tx_scheduler: TIMEOUT_CYC must be at least 2");
  end

  logic [0:0]       state, state_d;
  logic [IDX_W-1:0] rr_ptr, rr_ptr_d;
  logic [IDX_W-1:0] sel_q;
  logic [IDX_W-1:0] arb_ptr, arb_idx;
  logic [N_REQ-1:0] arb_oh;
  logic             arb_any;
  logic             load_c;
  logic             err_d;
  logic             tmo_hit;
  logic [ID_W-1:0]  dest_sel;
  logic [DATA_W-1:0] data_sel;
  logic [PKT_W-1:0] pkt_c;

  function automatic logic [IDX_W-1:0] inc_idx(input logic [IDX_W-1:0] i);
    return (i == IDX_W'(N_REQ - 1)) ? '0 : i + 1'b1;
  endfunction

  // In SEND a new pick only happens on transfer, so start just past the current packet
  assign arb_ptr = (state == SEND) ? inc_idx(sel_q) : rr_ptr;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .req       (req),
    .ptr       (arb_ptr),
    .any_c     (arb_any),
    .sel_oh_c  (arb_oh),
    .sel_idx_c (arb_idx)
  );

  always_comb begin
    dest_sel = '0;
    data_sel = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (arb_idx == IDX_W'(i)) begin
        dest_sel = req_dest[i*ID_W +: ID_W];
        data_sel = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign pkt_c = {dest_sel, node_id, data_sel};

`ifdef TX_SCHEDULER_TIMEOUT_EN
  localparam int unsigned TMO_W = idx_w(TIMEOUT_CYC);

  logic [TMO_W-1:0] tmo_cnt;

  assign tmo_hit = (state == SEND) && !tx_ready && (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));

  // Counts stalled SEND cycles of the current packet
  always_ff @(posedge clk) begin
    if (!rst) begin
      tmo_cnt <= '0;
    end else if ((state != SEND) || tx_ready || load_c) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_d  = state;
    rr_ptr_d = rr_ptr;
    load_c   = 1'b0;
    err_d    = 1'b0;
    case (state)
      IDLE: begin
        if (arb_any) begin
          load_c  = 1'b1;
          state_d = SEND;
        end
      end
      SEND: begin
        if (tx_ready) begin
          rr_ptr_d = inc_idx(sel_q);
          if (arb_any) load_c  = 1'b1;
          else         state_d = IDLE;
        end else if (tmo_hit) begin
          rr_ptr_d = inc_idx(sel_q);
          state_d  = IDLE;
          err_d    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // No grant may escape while reset is asserted
    if (!rst) load_c = 1'b0;
  end

  assign grant    = load_c ? arb_oh : '0;
  assign tx_valid = (state == SEND);
  assign busy     = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= IDLE;
      rr_ptr <= '0;
      sel_q  <= '0;
      tx_out <= '0;
      tx_err <= 1'b0;
    end else begin
      state  <= state_d;
      rr_ptr <= rr_ptr_d;
      tx_err <= err_d;
      if (load_c) begin
        sel_q  <= arb_idx;
        tx_out <= pkt_c;
      end
    end
  end

endmodule

// File: tb/tb_tx_scheduler.sv
// Self-checking bench for tx_scheduler: expected packets queued at grant, checked at transfer.
module tb_tx_scheduler;
  import txrx_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] node_id;
  logic [3:0] req;
  logic [1:0] dest [4];
  logic [1:0] data [4];
  logic [7:0] req_dest, req_data;
  logic [3:0] grant;
  logic [5:0] tx_out;
  logic       tx_valid, tx_ready, busy, tx_err;

  int errors = 0;
  int checks = 0;
  logic [5:0] exp_q [$];
  logic [5:0] exp_pkt;

  assign req_dest = {dest[3], dest[2], dest[1], dest[0]};
  assign req_data = {data[3], data[2], data[1], data[0]};

  always #5 clk = ~clk;

  tx_scheduler dut (
    .clk      (clk),
    .rst      (rst),
    .node_id  (node_id),
    .req      (req),
    .req_dest (req_dest),
    .req_data (req_data),
    .grant    (grant),
    .tx_out   (tx_out),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .busy     (busy),
    .tx_err   (tx_err)
  );

  function automatic logic [5:0] pkt_of(input logic [1:0] i);
    pkt_t p;
    p.dest = dest[i];
    p.src  = node_id;
    p.data = data[i];
    return p;
  endfunction

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b0; req = '0; tx_ready = 1'b0;
    next_cycle();
    rst = 1'b1;
    exp_q.delete();
  endtask

  task automatic test_reset;
    rst = 1'b0; req = 4'b1111; tx_ready = 1'b1;
    repeat (2) next_cycle();
    #2;
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid: got %b want 0", tx_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (tx_out !== 6'b0) begin errors++; $display("FAIL reset_tx_out: got %b want 000000", tx_out); end
    checks++; if (tx_err !== 1'b0) begin errors++; $display("FAIL reset_tx_err: got %b want 0", tx_err); end
    checks++; if (grant !== 4'b0) begin errors++; $display("FAIL reset_grant: got %b want 0000", grant); end
    req = '0;
  endtask

  task automatic test_single;
    do_reset();
    node_id = 2'b10; dest[0] = 2'b00; data[0] = 2'b01;
    req = 4'b0001; tx_ready = 1'b1;
    #2;
    checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL single_grant: got %b want 0001", grant); end
    exp_q.push_back(pkt_of(2'd0));
    next_cycle();
    req = '0;
    #2;
    checks++; if (tx_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b want 1", tx_valid); end
    checks++;
    if (exp_q.size() == 0) begin errors++; $display("FAIL single_pkt: got %b want <none queued>", tx_out); end
    else begin
      exp_pkt = exp_q.pop_front();
      if (tx_out !== exp_pkt) begin errors++; $display("FAIL single_pkt: got %b want %b", tx_out, exp_pkt); end
    end
    checks++; if (grant !== 4'b0) begin errors++; $display("FAIL single_no_regrant: got %b want 0000", grant); end
    next_cycle();
    #2;
    checks++; if (tx_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL single_idle: got valid=%b busy=%b want 0 0", tx_valid, busy); end
  endtask

  task automatic test_back_to_back;
    logic [3:0] exp_g;
    do_reset();
    node_id = 2'b01;
    for (int i = 0; i < 4; i++) begin dest[i] = 2'(3 - i); data[i] = 2'(i); end
    req = 4'b1111; tx_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #2;
      if (k > 0) begin
        checks++; if (tx_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid[%0d]: got %b want 1", k, tx_valid); end
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL b2b_pkt[%0d]: got %b want <none queued>", k, tx_out); end
        else begin
          exp_pkt = exp_q.pop_front();
          if (tx_out !== exp_pkt) begin errors++; $display("FAIL b2b_pkt[%0d]: got %b want %b", k, tx_out, exp_pkt); end
        end
      end
      exp_g = 4'b0001 << (k % 4);
      checks++; if (grant !== exp_g) begin errors++; $display("FAIL b2b_grant[%0d]: got %b want %b", k, grant, exp_g); end
      exp_q.push_back(pkt_of(2'(k % 4)));
      next_cycle();
    end
    req = '0;
    #2;
    checks++;
    if (exp_q.size() == 0) begin errors++; $display("FAIL b2b_last_pkt: got %b want <none queued>", tx_out); end
    else begin
      exp_pkt = exp_q.pop_front();
      if (tx_out !== exp_pkt) begin errors++; $display("FAIL b2b_last_pkt: got %b want %b", tx_out, exp_pkt); end
    end
    checks++; if (grant !== 4'b0) begin errors++; $display("FAIL b2b_drain_grant: got %b want 0000", grant); end
    next_cycle();
    #2;
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL b2b_idle: got %b want 0", tx_valid); end
  endtask

  task automatic test_stall;
    do_reset();
    node_id = 2'b10;
    dest[0] = 2'b01; data[0] = 2'b10;
    dest[2] = 2'b11; data[2] = 2'b01;
    req = 4'b0101; tx_ready = 1'b0;
    #2;
    checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL stall_grant0: got %b want 0001", grant); end
    exp_q.push_back(pkt_of(2'd0));
    next_cycle();
    // Inputs move after capture; the pending packet must not follow them
    req = 4'b0100; dest[0] = 2'b10; data[0] = 2'b11; node_id = 2'b01;
    for (int c = 0; c < 5; c++) begin
      #2;
      checks++; if (tx_valid !== 1'b1) begin errors++; $display("FAIL stall_valid[%0d]: got %b want 1", c, tx_valid); end
      checks++;
      if (exp_q.size() == 0 || tx_out !== exp_q[0]) begin errors++; $display("FAIL stall_hold[%0d]: got %b want %b", c, tx_out, exp_q[0]); end
      checks++; if (grant !== 4'b0) begin errors++; $display("FAIL stall_grant[%0d]: got %b want 0000", c, grant); end
      next_cycle();
    end
    tx_ready = 1'b1;
    #2;
    checks++;
    if (exp_q.size() == 0) begin errors++; $display("FAIL stall_pkt0: got %b want <none queued>", tx_out); end
    else begin
      exp_pkt = exp_q.pop_front();
      if (tx_out !== exp_pkt) begin errors++; $display("FAIL stall_pkt0: got %b want %b", tx_out, exp_pkt); end
    end
    checks++; if (grant !== 4'b0100) begin errors++; $display("FAIL stall_grant2: got %b want 0100", grant); end
    exp_q.push_back(pkt_of(2'd2));
    next_cycle();
    req = '0;
    #2;
    checks++;
    if (exp_q.size() == 0) begin errors++; $display("FAIL stall_pkt2: got %b want <none queued>", tx_out); end
    else begin
      exp_pkt = exp_q.pop_front();
      if (tx_out !== exp_pkt) begin errors++; $display("FAIL stall_pkt2: got %b want %b", tx_out, exp_pkt); end
    end
    next_cycle();
    #2;
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL stall_idle: got %b want 0", tx_valid); end
  endtask

  task automatic test_reset_in_send;
    do_reset();
    node_id = 2'b10;
    dest[0] = 2'b10; data[0] = 2'b00;
    dest[2] = 2'b01; data[2] = 2'b11;
    dest[3] = 2'b00; data[3] = 2'b10;
    req = 4'b0001; tx_ready = 1'b1;
    #2;
    checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL rsend_grant0: got %b want 0001", grant); end
    exp_q.push_back(pkt_of(2'd0));
    next_cycle();
    req = 4'b0100;
    #2;
    checks++;
    if (exp_q.size() == 0) begin errors++; $display("FAIL rsend_pkt0: got %b want <none queued>", tx_out); end
    else begin
      exp_pkt = exp_q.pop_front();
      if (tx_out !== exp_pkt) begin errors++; $display("FAIL rsend_pkt0: got %b want %b", tx_out, exp_pkt); end
    end
    checks++; if (grant !== 4'b0100) begin errors++; $display("FAIL rsend_grant2: got %b want 0100", grant); end
    exp_q.push_back(pkt_of(2'd2));
    next_cycle();
    req = '0; tx_ready = 1'b0;
    #2;
    checks++; if (tx_valid !== 1'b1) begin errors++; $display("FAIL rsend_pending: got %b want 1", tx_valid); end
    next_cycle();
    rst = 1'b0; req = 4'b1001; tx_ready = 1'b1;
    #2;
    checks++; if (grant !== 4'b0) begin errors++; $display("FAIL rsend_grant_in_rst: got %b want 0000", grant); end
    exp_q.delete();
    next_cycle();
    #2;
    checks++; if (tx_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rsend_flush: got valid=%b busy=%b want 0 0", tx_valid, busy); end
    checks++; if (tx_out !== 6'b0) begin errors++; $display("FAIL rsend_tx_out: got %b want 000000", tx_out); end
    next_cycle();
    rst = 1'b1;
    #2;
    // Pointer back at 0, so requester 0 wins over 3
    checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL rsend_ptr0: got %b want 0001", grant); end
    exp_q.push_back(pkt_of(2'd0));
    next_cycle();
    req = 4'b1000;
    #2;
    checks++;
    if (exp_q.size() == 0) begin errors++; $display("FAIL rsend_pkt_a: got %b want <none queued>", tx_out); end
    else begin
      exp_pkt = exp_q.pop_front();
      if (tx_out !== exp_pkt) begin errors++; $display("FAIL rsend_pkt_a: got %b want %b", tx_out, exp_pkt); end
    end
    checks++; if (grant !== 4'b1000) begin errors++; $display("FAIL rsend_grant3: got %b want 1000", grant); end
    exp_q.push_back(pkt_of(2'd3));
    next_cycle();
    req = '0;
    #2;
    checks++;
    if (exp_q.size() == 0) begin errors++; $display("FAIL rsend_pkt_b: got %b want <none queued>", tx_out); end
    else begin
      exp_pkt = exp_q.pop_front();
      if (tx_out !== exp_pkt) begin errors++; $display("FAIL rsend_pkt_b: got %b want %b", tx_out, exp_pkt); end
    end
  endtask

  task automatic test_timeout;
    do_reset();
    node_id = 2'b10;
    dest[0] = 2'b11; data[0] = 2'b01;
    dest[1] = 2'b01; data[1] = 2'b10;
    req = 4'b0001; tx_ready = 1'b0;
    #2;
    checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL tmo_grant: got %b want 0001", grant); end
    next_cycle();
    req = '0;
`ifdef TX_SCHEDULER_TIMEOUT_EN
    for (int c = 1; c <= 16; c++) begin
      #2;
      checks++; if (tx_valid !== 1'b1 || tx_err !== 1'b0) begin errors++; $display("FAIL tmo_wait[%0d]: got valid=%b err=%b want 1 0", c, tx_valid, tx_err); end
      next_cycle();
    end
    #2;
    checks++; if (tx_err !== 1'b1) begin errors++; $display("FAIL tmo_err_pulse: got %b want 1", tx_err); end
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL tmo_dropped: got %b want 0", tx_valid); end
    req = 4'b0011;
    #1;
    // Dropped packet still advances the pointer past requester 0
    checks++; if (grant !== 4'b0010) begin errors++; $display("FAIL tmo_ptr: got %b want 0010", grant); end
    next_cycle();
    req = '0;
    #2;
    checks++; if (tx_err !== 1'b0) begin errors++; $display("FAIL tmo_err_single: got %b want 0", tx_err); end
`else
    for (int c = 1; c <= 20; c++) begin
      #2;
      checks++; if (tx_valid !== 1'b1 || tx_err !== 1'b0) begin errors++; $display("FAIL tmo_hold[%0d]: got valid=%b err=%b want 1 0", c, tx_valid, tx_err); end
      next_cycle();
    end
`endif
    do_reset();
  endtask

  initial begin
    rst = 1'b0; node_id = 2'b10; req = '0; tx_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin dest[i] = '0; data[i] = '0; end
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_reset_in_send();
    test_timeout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
